// File: rtl/tof_pkg.sv
// rtl/tof_pkg.sv - shared ToF frame constants, FSM state and stream beat types
package tof_pkg;

    localparam int N_SENSORS    = 8;
    localparam int ZONES        = 64;
    localparam int TOF_ADDR_W   = 9;
    localparam int TOF_DATA_W   = 16;
    localparam int TOF_ZONE_W   = $clog2(ZONES);
    localparam int TOF_SENSOR_W = $clog2(N_SENSORS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tof_state_t;

    typedef struct packed {
        logic [TOF_DATA_W-1:0]   data;
        logic [TOF_SENSOR_W-1:0] sensor;
        logic [TOF_ZONE_W-1:0]   zone;
        logic                    last;
    } tof_beat_t;

endpackage

// File: rtl/tof_frame_streamer_if.sv
// rtl/tof_frame_streamer_if.sv - valid/ready ToF sample stream (data, sensor, zone, last)
// master: m_valid, m_data, m_sensor, m_zone, m_last out; m_ready in.
// slave:  mirror of master.
interface tof_frame_streamer_if
    import tof_pkg::*;
#(
    parameter int DATA_W = TOF_DATA_W,
    parameter int ADDR_W = TOF_ADDR_W,
    parameter int ZONE_W = TOF_ZONE_W
);
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic [ADDR_W-ZONE_W-1:0] m_sensor;
    logic [ZONE_W-1:0]        m_zone;
    logic                     m_last;

    modport master (
        output m_valid, m_data, m_sensor, m_zone, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_sensor, m_zone, m_last,
        output m_ready
    );
endinterface

// File: rtl/tof_skid_fifo.sv
// rtl/tof_skid_fifo.sv - small synchronous FIFO absorbing BRAM read latency
// Ports: clk, reset (async active-low), push/din write side, pop/dout read side
// (dout is the current head, valid while !empty), full, empty, count.
module tof_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so push into a full FIFO is fine then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tof_frame_streamer.sv
// rtl/tof_frame_streamer.sv - streams one ToF frame from BRAM port B with sensor/zone tags
// Ports: clk, reset (async active-low), drdy (frame-written pulse), addrb/doutb
// (BRAM port B), m (stream master), busy, frame_done (pulse after last beat),
// overrun_cnt (saturating count of drdy ignored while busy).
// Optional TOF_FRAME_STATS_EN: frame_min, frame_max, frame_zero_cnt per frame.
module tof_frame_streamer
    import tof_pkg::*;
#(
    parameter int ADDR_W = TOF_ADDR_W,
    parameter int DATA_W = TOF_DATA_W,
    parameter int ZONE_W = TOF_ZONE_W,
    parameter int RD_LAT = 1,
    parameter int OVR_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 drdy,
    output logic [ADDR_W-1:0]    addrb,
    input  logic [DATA_W-1:0]    doutb,
    tof_frame_streamer_if.master m,
    output logic                 busy,
    output logic                 frame_done,
    output logic [OVR_W-1:0]     overrun_cnt
`ifdef TOF_FRAME_STATS_EN
    ,
    output logic [DATA_W-1:0]    frame_min,
    output logic [DATA_W-1:0]    frame_max,
    output logic [ADDR_W:0]      frame_zero_cnt
`endif
);
    localparam int DEPTH  = RD_LAT + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = DATA_W + ADDR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    tof_state_t state, state_nxt;

    logic [RD_LAT-1:0] tag_v;
    logic [ADDR_W-1:0] tag_a [RD_LAT];
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W:0]    occ;
    logic              issue, pop, push, drain_done;

    logic [BEAT_W-1:0] fifo_din, fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Read issue: credits count FIFO slots not yet claimed by stored words or
    // reads in flight. A pop this cycle frees a slot that a read issued now
    // can only fill RD_LAT cycles later, so it counts as a credit already.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_v[i]);
        end
        occ   = {1'b0, fifo_count} + {1'b0, inflight} - (CNT_W + 1)'(pop);
        issue = (state == READ) && (occ < DEPTH_C);
    end

    assign push     = tag_v[RD_LAT-1];
    assign fifo_din = {doutb, tag_a[RD_LAT-1], (tag_a[RD_LAT-1] == '1)};
    assign pop      = m.m_valid && m.m_ready;

    // Look ahead by one pop so frame_done follows the final handshake directly.
    assign drain_done = (tag_v == '0) &&
                        (fifo_empty || (fifo_count == CNT_W'(1) && pop));

    // Issue-valid/address tag pipe, aligned with doutb on exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_a[i] <= '0;
        end else begin
            tag_v[0] <= issue;
            tag_a[0] <= addrb;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_a[i] <= tag_a[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrb <= '0;
        end else if (state == IDLE && drdy) begin
            addrb <= '0;
        end else if (issue) begin
            addrb <= addrb + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (drdy && state != IDLE && overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drdy) state_nxt = READ;
            READ:    if (issue && addrb == '1) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state == READ) || (state == DRAIN);
        frame_done = (state == DONE);
    end

    tof_skid_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    fifo_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && fifo_full && !pop));

    assign m.m_valid = !fifo_empty;
    assign {m.m_data, m.m_sensor, m.m_zone, m.m_last} = fifo_dout;

`ifdef TOF_FRAME_STATS_EN
    logic [DATA_W-1:0] run_min, run_max;
    logic [ADDR_W:0]   run_zero;

    // Zero means "no return" and is counted rather than treated as a minimum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_min        <= '1;
            run_max        <= '0;
            run_zero       <= '0;
            frame_min      <= '1;
            frame_max      <= '0;
            frame_zero_cnt <= '0;
        end else begin
            if (state == IDLE && drdy) begin
                run_min  <= '1;
                run_max  <= '0;
                run_zero <= '0;
            end else if (pop) begin
                if (m.m_data == '0)         run_zero <= run_zero + 1'b1;
                else if (m.m_data < run_min) run_min  <= m.m_data;
                if (m.m_data > run_max)      run_max  <= m.m_data;
            end
            if (state == DONE) begin
                frame_min      <= run_min;
                frame_max      <= run_max;
                frame_zero_cnt <= run_zero;
            end
        end
    end
`endif
endmodule

// File: tb/tb_tof_frame_streamer.sv
// tb/tb_tof_frame_streamer.sv - directed bench for tof_frame_streamer at RD_LAT=1 and RD_LAT=2
module tb_tof_frame_streamer;
    import tof_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, drdy, m_ready;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] mem [512];
    logic [8:0]  addrb0, addrb1;
    logic [15:0] rd0_q, rd1_q1, rd1_q2;
    logic        busy0, busy1, fd0, fd1;
    logic [7:0]  ov0, ov1;

    // BRAM port-B models: 1-cycle and 2-cycle read latency
    always @(posedge clk) begin
        rd0_q  <= mem[addrb0];
        rd1_q1 <= mem[addrb1];
        rd1_q2 <= rd1_q1;
    end

    tof_frame_streamer_if s0 ();
    tof_frame_streamer_if s1 ();
    assign s0.m_ready = m_ready;
    assign s1.m_ready = m_ready;

`ifdef TOF_FRAME_STATS_EN
    logic [15:0] fmin0, fmax0, fmin1, fmax1;
    logic [9:0]  fz0, fz1;
`endif

    tof_frame_streamer #(.RD_LAT(1)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .drdy        (drdy),
        .addrb       (addrb0),
        .doutb       (rd0_q),
        .m           (s0),
        .busy        (busy0),
        .frame_done  (fd0),
        .overrun_cnt (ov0)
`ifdef TOF_FRAME_STATS_EN
        ,
        .frame_min      (fmin0),
        .frame_max      (fmax0),
        .frame_zero_cnt (fz0)
`endif
    );

    tof_frame_streamer #(.RD_LAT(2)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .drdy        (drdy),
        .addrb       (addrb1),
        .doutb       (rd1_q2),
        .m           (s1),
        .busy        (busy1),
        .frame_done  (fd1),
        .overrun_cnt (ov1)
`ifdef TOF_FRAME_STATS_EN
        ,
        .frame_min      (fmin1),
        .frame_max      (fmax1),
        .frame_zero_cnt (fz1)
`endif
    );

    logic      mv [2];
    logic      busy_a [2];
    logic      fd_a [2];
    logic [8:0] ab [2];
    logic [7:0] ov [2];
    tof_beat_t beat_a [2];

    assign mv[0] = s0.m_valid;
    assign mv[1] = s1.m_valid;
    assign busy_a[0] = busy0;
    assign busy_a[1] = busy1;
    assign fd_a[0] = fd0;
    assign fd_a[1] = fd1;
    assign ab[0] = addrb0;
    assign ab[1] = addrb1;
    assign ov[0] = ov0;
    assign ov[1] = ov1;
    assign beat_a[0] = {s0.m_data, s0.m_sensor, s0.m_zone, s0.m_last};
    assign beat_a[1] = {s1.m_data, s1.m_sensor, s1.m_zone, s1.m_last};

    task automatic test_reset();
        reset = 1'b0;
        drdy = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (ab[d] !== 9'd0) begin n_fail++; $display("FAIL reset_addrb dut%0d: got %0d expected 0", d, ab[d]); end
            n_tests++; if (mv[d] !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid dut%0d: got %b expected 0", d, mv[d]); end
            n_tests++; if (beat_a[d].last !== 1'b0 && mv[d] !== 1'b0) begin n_fail++; $display("FAIL reset_m_last dut%0d: got %b expected 0", d, beat_a[d].last); end
            n_tests++; if (busy_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b expected 0", d, busy_a[d]); end
            n_tests++; if (fd_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done dut%0d: got %b expected 0", d, fd_a[d]); end
            n_tests++; if (ov[d] !== 8'd0) begin n_fail++; $display("FAIL reset_overrun dut%0d: got %0d expected 0", d, ov[d]); end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (busy_a[d] !== 1'b0 || mv[d] !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset dut%0d: got busy=%b valid=%b expected 0/0", d, busy_a[d], mv[d]); end
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: overrun pulses, 3: ready low for 20 cycles
    task automatic run_stream(input int mode);
        int        k [2];
        int        last_c [2];
        int        done_c [2];
        logic      stall [2];
        tof_beat_t held [2];
        tof_beat_t exp_b;
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; last_c[d] = -1; done_c[d] = -1; stall[d] = 1'b0; held[d] = '0;
        end
        @(negedge clk);
        drdy = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        #1 drdy = 1'b0;
        for (int c = 0; c < 4000 && (done_c[0] < 0 || done_c[1] < 0); c++) begin
            @(negedge clk);
            if (mode == 2) drdy = (c == 10 || c == 20 || c == 30 || (c >= 50 && c < 350));
            case (mode)
                1:       m_ready = 1'($urandom_range(1, 0));
                3:       m_ready = (c >= 20);
                default: m_ready = 1'b1;
            endcase
            for (int d = 0; d < 2; d++) begin
                if (mode == 2 && c == 40) begin
                    n_tests++; if (ov[d] !== 8'd3) begin n_fail++; $display("FAIL overrun_three dut%0d: got %0d expected 3", d, ov[d]); end
                end
                if (mode == 2 && c == 360) begin
                    n_tests++; if (ov[d] !== 8'd255) begin n_fail++; $display("FAIL overrun_saturate dut%0d: got %0d expected 255", d, ov[d]); end
                end
                if (mode == 3 && c == 19) begin
                    n_tests++; if (ab[d] !== 9'(d + 2)) begin n_fail++; $display("FAIL stall_addrb dut%0d: got %0d expected %0d", d, ab[d], d + 2); end
                    n_tests++; if (mv[d] !== 1'b1) begin n_fail++; $display("FAIL stall_valid dut%0d: got %b expected 1", d, mv[d]); end
                end
                if (stall[d]) begin
                    n_tests++;
                    if (mv[d] !== 1'b1 || beat_a[d] !== held[d]) begin
                        n_fail++; $display("FAIL stall_hold dut%0d: got valid=%b beat=%h expected valid=1 beat=%h", d, mv[d], beat_a[d], held[d]);
                    end
                end
                if (mv[d] && m_ready) begin
                    exp_b.data   = (k[d] < 512) ? mem[k[d]] : 16'hxxxx;
                    exp_b.sensor = 3'(k[d] >> 6);
                    exp_b.zone   = 6'(k[d] & 63);
                    exp_b.last   = (k[d] == 511);
                    n_tests++;
                    if (beat_a[d] !== exp_b) begin
                        n_fail++; $display("FAIL beat%0d dut%0d: got %h expected %h", k[d], d, beat_a[d], exp_b);
                    end
                    if (mode == 0) begin
                        n_tests++;
                        if (c !== k[d] + d + 2) begin n_fail++; $display("FAIL beat_timing%0d dut%0d: got cycle %0d expected %0d", k[d], d, c, k[d] + d + 2); end
                    end
                    if (k[d] == 511) last_c[d] = c;
                    k[d]++;
                end
                stall[d] = mv[d] && !m_ready;
                held[d]  = beat_a[d];
                if (fd_a[d] && done_c[d] < 0) done_c[d] = c;
            end
        end
        drdy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (k[d] !== 512) begin n_fail++; $display("FAIL beat_count mode%0d dut%0d: got %0d expected 512", mode, d, k[d]); end
            n_tests++; if (done_c[d] !== last_c[d] + 1 || done_c[d] < 0) begin n_fail++; $display("FAIL frame_done_cycle mode%0d dut%0d: got %0d expected %0d", mode, d, done_c[d], last_c[d] + 1); end
            n_tests++; if (busy_a[d] !== 1'b0) begin n_fail++; $display("FAIL busy_after mode%0d dut%0d: got %b expected 0", mode, d, busy_a[d]); end
        end
    endtask

    task automatic test_full_frame();
        run_stream(0);
    endtask

    task automatic test_ready_stall();
        run_stream(3);
    endtask

    task automatic test_random_ready();
        run_stream(1);
    endtask

    task automatic test_overrun();
        run_stream(2);
    endtask

    task automatic test_reset_mid_frame();
        int cnt = 0;
        @(negedge clk);
        drdy = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1 drdy = 1'b0;
        for (int c = 0; c < 400 && cnt < 200; c++) begin
            @(negedge clk);
            if (mv[0] && m_ready) cnt++;
        end
        @(negedge clk);
        m_ready = 1'b0;
        n_tests++; if (beat_a[0].data !== 16'd600) begin n_fail++; $display("FAIL head_before_reset: got %0d expected 600", beat_a[0].data); end
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (mv[d] !== 1'b0) begin n_fail++; $display("FAIL abort_valid dut%0d: got %b expected 0", d, mv[d]); end
            n_tests++; if (busy_a[d] !== 1'b0) begin n_fail++; $display("FAIL abort_busy dut%0d: got %b expected 0", d, busy_a[d]); end
            n_tests++; if (ab[d] !== 9'd0) begin n_fail++; $display("FAIL abort_addrb dut%0d: got %0d expected 0", d, ab[d]); end
            n_tests++; if (ov[d] !== 8'd0) begin n_fail++; $display("FAIL abort_overrun dut%0d: got %0d expected 0", d, ov[d]); end
            n_tests++; if (fd_a[d] !== 1'b0) begin n_fail++; $display("FAIL abort_frame_done dut%0d: got %b expected 0", d, fd_a[d]); end
        end
        @(negedge clk);
        reset = 1'b1;
        run_stream(0);
    endtask

`ifdef TOF_FRAME_STATS_EN
    task automatic test_stats();
        logic [15:0] fmin [2];
        logic [15:0] fmax [2];
        logic [9:0]  fz [2];
        fmin[0] = fmin0; fmin[1] = fmin1; fmax[0] = fmax0; fmax[1] = fmax1; fz[0] = fz0; fz[1] = fz1;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (fmin[d] !== 16'd3) begin n_fail++; $display("FAIL stats_prev_min dut%0d: got %0d expected 3", d, fmin[d]); end
            n_tests++; if (fmax[d] !== 16'd1533) begin n_fail++; $display("FAIL stats_prev_max dut%0d: got %0d expected 1533", d, fmax[d]); end
            n_tests++; if (fz[d] !== 10'd1) begin n_fail++; $display("FAIL stats_prev_zero dut%0d: got %0d expected 1", d, fz[d]); end
        end
        for (int i = 0; i < 512; i++) mem[i] = 16'd100;
        mem[5] = 16'd0;
        mem[9] = 16'd7;
        mem[400] = 16'd900;
        run_stream(0);
        @(negedge clk);
        fmin[0] = fmin0; fmin[1] = fmin1; fmax[0] = fmax0; fmax[1] = fmax1; fz[0] = fz0; fz[1] = fz1;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (fmin[d] !== 16'd7) begin n_fail++; $display("FAIL stats_min dut%0d: got %0d expected 7", d, fmin[d]); end
            n_tests++; if (fmax[d] !== 16'd900) begin n_fail++; $display("FAIL stats_max dut%0d: got %0d expected 900", d, fmax[d]); end
            n_tests++; if (fz[d] !== 10'd1) begin n_fail++; $display("FAIL stats_zero dut%0d: got %0d expected 1", d, fz[d]); end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(3 * i);
        test_reset();
        test_full_frame();
        test_ready_stall();
        test_random_ready();
        test_overrun();
        test_reset_mid_frame();
`ifdef TOF_FRAME_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
